// File: rtl/mem_pkg.sv
// Shared encodings for the main_memory block: access sizes, FSM states
// and the burst length, plus the alignment rule used on request acceptance.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'b00,
    SIZE_HALF   = 2'b01,
    SIZE_WORD   = 2'b10,
    SIZE_BURST4 = 2'b11
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RD_BURST = 2'b01,
    WR_BURST = 2'b10
  } mem_state_t;

  localparam int BURST_LEN = 4;

  // Bursts must start on a 16-byte boundary so that they never wrap.
  function automatic logic is_misaligned(input access_size_t size, input logic [3:0] addr_lo);
    case (size)
      SIZE_BYTE:   return 1'b0;
      SIZE_HALF:   return addr_lo[0];
      SIZE_WORD:   return addr_lo[1:0] != 2'b00;
      default:     return addr_lo != 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane handling for sub-word accesses: write byte enables and lane
// replication on the way in, lane extraction with zero-extension on the way out.
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_pkg::access_size_t size_in,
  input  logic [1:0]            addr_lo_in,
  input  logic [31:0]           wr_data_in,
  input  logic [31:0]           rd_word_in,
  output logic [3:0]            byte_en_out,
  output logic [31:0]           wr_data_out,
  output logic [31:0]           rd_data_out
);

  // Write data is replicated across lanes so the byte enables alone pick the target lane.
  always_comb begin
    byte_en_out = 4'hF;
    wr_data_out = wr_data_in;
    rd_data_out = rd_word_in;
    case (size_in)
      SIZE_BYTE: begin
        byte_en_out = 4'b0001 << addr_lo_in;
        wr_data_out = {4{wr_data_in[7:0]}};
        rd_data_out = {24'h0, rd_word_in[8*addr_lo_in +: 8]};
      end
      SIZE_HALF: begin
        byte_en_out = 4'b0011 << addr_lo_in;
        wr_data_out = {2{wr_data_in[15:0]}};
        rd_data_out = {16'h0, rd_word_in[16*addr_lo_in[1] +: 16]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/main_memory.sv
// Word-organised memory with byte/halfword/word single accesses and
// four-beat bursts; one request at a time, misaligned or out-of-range rejected.
module main_memory
  import mem_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        enable_in,
  input  logic [31:0] addr_in,
  input  logic        rw_in,
  input  logic [1:0]  access_size_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        busy_out,
  output logic        error_out
);

  localparam int          AW        = (MEM_WORDS > 4) ? $clog2(MEM_WORDS) : 2;
  localparam logic [31:0] LAST_WORD = 32'(MEM_WORDS - 1);

  logic [31:0]  mem [MEM_WORDS];

  mem_state_t   state;
  logic [1:0]   beat;
  logic [AW-1:0] burst_idx;

  access_size_t req_size;
  logic [31:0]  word_idx;
  logic [31:0]  req_span;
  logic         req_ok;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] beat_idx;

  logic [3:0]   lane_be;
  logic [31:0]  lane_wdata;
  logic [31:0]  lane_rdata;

  logic         wr_en;
  logic [AW-1:0] wr_idx;
  logic [3:0]   wr_be;
  logic [31:0]  wr_word;

  assign req_size = access_size_t'(access_size_in);
  assign word_idx = (addr_in - BASE_ADDR) >> 2;
  assign req_span = (req_size == SIZE_BURST4) ? 32'(BURST_LEN - 1) : 32'd0;
  assign req_idx  = word_idx[AW-1:0];
  assign beat_idx = burst_idx + AW'(beat);

  // The last word touched by the request must lie inside the array.
  assign req_ok = !is_misaligned(req_size, addr_in[3:0])
               && (addr_in >= BASE_ADDR)
               && (word_idx + req_span <= LAST_WORD);

  mem_lane_align u_lane_align (
    .size_in     (req_size),
    .addr_lo_in  (addr_in[1:0]),
    .wr_data_in  (data_in),
    .rd_word_in  (mem[req_idx]),
    .byte_en_out (lane_be),
    .wr_data_out (lane_wdata),
    .rd_data_out (lane_rdata)
  );

  // Writes are blocked while reset is held so an aborted burst leaves no trace.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = req_idx;
    wr_be   = lane_be;
    wr_word = lane_wdata;
    if (rst_n_in) begin
      if (state == WR_BURST) begin
        wr_en   = 1'b1;
        wr_idx  = beat_idx;
        wr_be   = 4'hF;
        wr_word = data_in;
      end else if (state == IDLE && enable_in && req_ok && rw_in) begin
        wr_en = 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      beat      <= 2'd0;
      burst_idx <= '0;
      data_out  <= 32'h0;
      valid_out <= 1'b0;
      busy_out  <= 1'b0;
      error_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      error_out <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_in) begin
            if (!req_ok) begin
              error_out <= 1'b1;
            end else begin
              if (!rw_in) begin
                data_out  <= lane_rdata;
                valid_out <= 1'b1;
              end
              if (req_size == SIZE_BURST4) begin
                state     <= rw_in ? WR_BURST : RD_BURST;
                busy_out  <= 1'b1;
                beat      <= 2'd1;
                burst_idx <= req_idx;
              end
            end
          end
        end
        RD_BURST, WR_BURST: begin
          if (state == RD_BURST) begin
            data_out  <= mem[beat_idx];
            valid_out <= 1'b1;
          end
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
          beat     <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// Randomised self-checking bench for main_memory against a word-array
// reference model; includes the directed scenarios and address boundaries.
module tb_main_memory;

  localparam int MEM_WORDS = 1024;

  logic        clk_in;
  logic        rst_n_in;
  logic        enable_in;
  logic [31:0] addr_in;
  logic        rw_in;
  logic [1:0]  access_size_in;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        busy_out;
  logic        error_out;

  int          checks;
  int          failures;
  logic [31:0] model_mem [MEM_WORDS];
  logic [31:0] last_read;

  main_memory #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(32'h0)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .enable_in      (enable_in),
    .addr_in        (addr_in),
    .rw_in          (rw_in),
    .access_size_in (access_size_in),
    .data_in        (data_in),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .busy_out       (busy_out),
    .error_out      (error_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] word;
    word = model_mem[addr >> 2];
    case (size)
      2'b00:   return (word >> (8 * (addr % 4))) & 32'hFF;
      2'b01:   return (word >> (8 * (addr % 4))) & 32'hFFFF;
      default: return word;
    endcase
  endfunction

  task automatic model_write(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] mask;
    case (size)
      2'b00:   mask = 32'hFF << (8 * (addr % 4));
      2'b01:   mask = 32'hFFFF << (8 * (addr % 4));
      default: mask = 32'hFFFF_FFFF;
    endcase
    model_mem[addr >> 2] = (model_mem[addr >> 2] & ~mask) | ((data << (8 * (addr % 4))) & mask);
  endtask

  // distract: 0 = quiet during burst beats, 1 = random extra requests, 2 = forced word write to 0x24
  task automatic applyStimulus(input logic rw, input logic [1:0] size, input logic [31:0] addr,
                               input logic [3:0][31:0] wdata, input int distract);
    int     beats;
    logic   bad;
    longint first_word;
    beats      = (size == 2'b11) ? 4 : 1;
    first_word = longint'(addr >> 2);
    bad = (size == 2'b01 && addr % 2 != 0) || (size == 2'b10 && addr % 4 != 0) ||
          (size == 2'b11 && addr % 16 != 0) || (first_word + beats - 1 > MEM_WORDS - 1);
    @(negedge clk_in);
    enable_in = 1'b1; rw_in = rw; access_size_in = size; addr_in = addr; data_in = wdata[0];
    @(posedge clk_in); #1;
    checkOutput("error", error_out, bad);
    if (bad) begin
      checkOutput("err_valid", valid_out, 1'b0);
      checkOutput("err_busy", busy_out, 1'b0);
    end else begin
      for (int k = 0; k < beats; k++) begin
        if (!rw) begin
          last_read = (size == 2'b11) ? model_mem[(addr >> 2) + k] : model_read(size, addr);
          checkOutput("rd_valid", valid_out, 1'b1);
          checkOutput("rd_data", data_out, last_read);
        end else begin
          if (size == 2'b11) model_mem[(addr >> 2) + k] = wdata[k];
          else model_write(size, addr, wdata[0]);
          checkOutput("wr_valid", valid_out, 1'b0);
        end
        checkOutput("busy", busy_out, (size == 2'b11 && k < 3));
        if (k > 0) checkOutput("burst_error", error_out, 1'b0);
        if (k < beats - 1) begin
          @(negedge clk_in);
          data_in = wdata[k + 1];
          enable_in = 1'b0;
          if (distract == 1) begin
            enable_in = 1'($urandom_range(0, 1)); rw_in = 1'($urandom_range(0, 1));
            access_size_in = 2'($urandom_range(0, 3)); addr_in = 32'($urandom_range(0, 4095));
          end else if (distract == 2) begin
            enable_in = 1'b1; rw_in = 1'b1; access_size_in = 2'b10; addr_in = 32'h24;
          end
          @(posedge clk_in); #1;
        end
      end
    end
    @(negedge clk_in);
    enable_in = 1'b0;
    @(posedge clk_in); #1;
    checkOutput("idle_valid", valid_out, 1'b0);
    checkOutput("idle_busy", busy_out, 1'b0);
    checkOutput("idle_error", error_out, 1'b0);
    checkOutput("hold_data", data_out, last_read);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [3:0][31:0] wd;
    logic [31:0]      a;
    logic [1:0]       sz;
    checks = 0; failures = 0; last_read = 32'h0;
    rst_n_in = 1'b1; enable_in = 1'b0; rw_in = 1'b0; access_size_in = 2'b00;
    addr_in = 32'h0; data_in = 32'h0;
    #2 rst_n_in = 1'b0;
    #1;
    checkOutput("rst_data", data_out, 32'h0);
    checkOutput("rst_valid", valid_out, 1'b0);
    checkOutput("rst_busy", busy_out, 1'b0);
    checkOutput("rst_error", error_out, 1'b0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;

    // Fill the whole array through bursts so every later read has a known value.
    for (int i = 0; i < MEM_WORDS / 4; i++) begin
      for (int k = 0; k < 4; k++) wd[k] = $urandom;
      applyStimulus(1'b1, 2'b11, 32'(i * 16), wd, 1);
    end

    wd = '0;
    wd[0] = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 2'b10, 32'h10, wd, 0);
    applyStimulus(1'b0, 2'b10, 32'h10, wd, 0);
    wd[0] = 32'h0000_00AA;
    applyStimulus(1'b1, 2'b00, 32'h11, wd, 0);
    applyStimulus(1'b0, 2'b00, 32'h11, wd, 0);
    applyStimulus(1'b0, 2'b10, 32'h10, wd, 0);
    checkOutput("byte_merge", data_out, 32'hDEAD_AAEF);

    wd = {32'h4, 32'h3, 32'h2, 32'h1};
    applyStimulus(1'b1, 2'b11, 32'h20, wd, 0);
    wd = {32'h99, 32'h99, 32'h99, 32'h99};
    applyStimulus(1'b0, 2'b11, 32'h20, wd, 2);
    applyStimulus(1'b0, 2'b10, 32'h24, wd, 0);
    checkOutput("ignored_req", data_out, 32'h2);

    applyStimulus(1'b0, 2'b10, 32'h12, wd, 0);
    applyStimulus(1'b0, 2'b01, 32'h13, wd, 0);
    applyStimulus(1'b1, 2'b10, 32'h12, wd, 0);
    applyStimulus(1'b0, 2'b10, 32'h10, wd, 0);

    wd = {32'h0, 32'h0, 32'h0, 32'h5A5A_0FF0};
    applyStimulus(1'b1, 2'b10, 32'hFFC, wd, 0);
    applyStimulus(1'b0, 2'b10, 32'hFFC, wd, 0);
    applyStimulus(1'b0, 2'b00, 32'hFFF, wd, 0);
    applyStimulus(1'b0, 2'b11, 32'hFF0, wd, 0);
    applyStimulus(1'b0, 2'b11, 32'h1000, wd, 0);
    applyStimulus(1'b1, 2'b10, 32'h1000, wd, 0);
    applyStimulus(1'b0, 2'b11, 32'h28, wd, 0);

    // Burst write to 0x40 interrupted by reset after its second beat.
    @(negedge clk_in);
    enable_in = 1'b1; rw_in = 1'b1; access_size_in = 2'b11; addr_in = 32'h40; data_in = 32'hA000_0000;
    @(posedge clk_in);
    model_mem[16] = 32'hA000_0000;
    @(negedge clk_in);
    enable_in = 1'b0; data_in = 32'hA000_0001;
    @(posedge clk_in);
    model_mem[17] = 32'hA000_0001;
    @(negedge clk_in);
    data_in = 32'hA000_0002;
    #2 rst_n_in = 1'b0;
    #1;
    checkOutput("abort_data", data_out, 32'h0);
    checkOutput("abort_valid", valid_out, 1'b0);
    checkOutput("abort_busy", busy_out, 1'b0);
    last_read = 32'h0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 2'b10, 32'(32'h40 + 4 * k), wd, 0);

    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(32'hFE0, 32'h101F));
        default: a = 32'($urandom_range(0, 4095));
      endcase
      if ($urandom_range(0, 9) < 8) begin
        case (sz)
          2'b01:   a = a & ~32'h1;
          2'b10:   a = a & ~32'h3;
          2'b11:   a = a & ~32'hF;
          default: ;
        endcase
      end
      for (int k = 0; k < 4; k++) wd[k] = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), sz, a, wd, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
